sh_ext_bus_responder: RTL and testbench
=======================================

Name: sh_ext_bus_responder

Overview:
- Target-side model of the SH7034 external bus: decodes CS_N/RD_N/WRH_N/WRL_N/A and turns each CPU bus cycle into one request on a simple synchronous memory port (BRAM, SDRAM controller, peripheral).
- Holds WAIT_N low until the memory side acknowledges, then presents read data for the CPU to latch in T2.
- Sits on the board side of the CPU core, in the same clock/CE domain.

Parameters:
- AREA_EN, 8'h01, bit n=1: this block answers CSn; other areas are ignored.
- AREA16, 8'h01, bit n=1: area n is 16-bit wide; 0: area n is 8-bit (data on D7..D0).
- TIMEOUT, 255, maximum CE_R periods WAIT_N may stay low before a forced completion (1..255).

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- CE_R  in  1  rising-phase clock enable (same as CPU)
- CE_F  in  1  falling-phase clock enable (same as CPU)
- A  in  24  CPU address
- DI  in  16  CPU write data (CPU DO)
- DO  out  16  read data to CPU DI
- CS_N  in  8  chip selects
- RD_N  in  1  read strobe
- WRH_N  in  1  upper-byte write strobe
- WRL_N  in  1  lower-byte write strobe
- WAIT_N  out  1  wait request to CPU
- MEM_A  out  24  memory address
- MEM_AREA  out  3  selected area index
- MEM_DO  out  16  memory write data
- MEM_BE  out  2  byte enables {hi,lo}
- MEM_WE  out  1  1 = write
- MEM_REQ  out  1  request, level; held until MEM_ACK
- MEM_DI  in  16  memory read data, valid with MEM_ACK
- MEM_ACK  in  1  one-CLK completion pulse
- ERR  out  1  one-CLK pulse on timeout

Behaviour:
- Reset values: DO=16'hFFFF, WAIT_N=1, MEM_REQ=0, MEM_WE=0, MEM_BE=0, MEM_A=0, MEM_AREA=0, MEM_DO=0, ERR=0, state IDLE, timeout counter 0.
- The CPU changes strobes on CE_R. This block samples bus inputs on CE_F only.
- SEL: exactly one CS_N[n] low with AREA_EN[n]=1. Several CS_N low at once: the lowest-indexed enabled one wins.
- STB: !RD_N | !WRH_N | !WRL_N.
- State IDLE, on CE_F with SEL&STB:
  - latch area n into MEM_AREA.
  - 16-bit area: MEM_A={A[23:1],1'b0}; MEM_BE = read ? 2'b11 : {!WRH_N,!WRL_N}; MEM_DO=DI.
  - 8-bit area: MEM_A=A; MEM_BE=2'b01; MEM_DO={8'h00,DI[7:0]}.
  - MEM_WE=RD_N; MEM_REQ=1; WAIT_N=0; counter cleared; go to ACCESS.
- ACCESS, on MEM_ACK (any CLK, CE not required):
  - MEM_REQ=0.
  - if read: DO=MEM_DI (16-bit area) or {8'h00,MEM_DI[7:0]} (8-bit area).
  - WAIT_N=1 at the next CE_F (not earlier, to keep it stable across CE_R); go to HOLD.
- ACCESS timeout: counter increments on each CE_R while no ack. On reaching TIMEOUT: MEM_REQ=0, DO=16'hFFFF, ERR pulses one CLK, WAIT_N=1 at next CE_F, go to HOLD.
  - a later stray MEM_ACK is ignored.
- HOLD:
  - DO stays stable.
  - on CE_F with !STB (all strobes high), go to IDLE; DO is kept.
  - CS_N staying low between bytes of a multi-byte 8-bit sequence is normal. Each strobe reassertion after a release is a new access.
- Abort: strobes released in ACCESS before ack, sampled on CE_F:
  - MEM_REQ=0, WAIT_N=1, go to IDLE.
  - a MEM_ACK in the same CLK is consumed and discarded.
- MEM_ACK while IDLE or HOLD: ignored.
- Latency with an ack in the same CLK as the request: WAIT_N low for exactly one CE_F–CE_F period. The CPU's one TW is satisfied.
- Served areas must be configured in WCR1 with ≥1 wait state; 0-wait areas do not sample WAIT_N. This is a system constraint, not checked by this block.
- Timeout counter is 8 bits; it saturates and never wraps.
- RST_N assertion mid-access: immediate return to reset values; an outstanding memory op is abandoned (memory must tolerate REQ drop).

Decomposition:
- Package SH7034_PKG gains:
  - typedef ExtRespState_t {IDLE, ACCESS, HOLD}.
  - constant EXT_OPEN_BUS = 16'hFFFF.
- No sub-module.
- Area-select priority encoder: local function.

Test Plan:
- 16-bit read, area0, A=24'h000102, MEM_ACK 3 CLK after REQ with MEM_DI=16'hBEEF → MEM_A=24'h000102, MEM_BE=11, MEM_WE=0; WAIT_N low until after ack; DO=16'hBEEF at CPU CE_F in T2.
- Byte write on 16-bit area: WRH_N=0, WRL_N=1, DI=16'h5A00 → MEM_BE=10, MEM_DO=16'h5A00, MEM_WE=1, one REQ only.
- 8-bit area 2 (AREA16[2]=0), CPU long write 32'h11223344 as four byte cycles with CS_N2 held low → four REQs, MEM_A +0..+3, MEM_DO low bytes 11,22,33,44, MEM_BE=01 each.
- No MEM_ACK, TIMEOUT=4 → ERR pulse after 4 CE_R, DO=16'hFFFF, WAIT_N released, later ACK ignored, next access served normally.
- Access to area 5 with AREA_EN[5]=0 → MEM_REQ stays 0, WAIT_N stays 1.
- RST_N low during ACCESS → MEM_REQ=0, WAIT_N=1, DO=16'hFFFF immediately; after release a new read completes correctly.

Source files
------------

// File: rtl/sh7034_pkg.sv
// Shared SH7034 board-side types and constants.
// Holds the external bus responder state type and open-bus value.
package sh7034_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    HOLD
  } ExtRespState_t;

  localparam logic [15:0] EXT_OPEN_BUS = 16'hFFFF;

endpackage

// File: rtl/sh_ext_bus_responder.sv
// SH7034 external bus target: turns CPU bus cycles on enabled areas
// into level requests on a simple memory port, stalling via WAIT_N.
// Ports:
//   CLK, RST_N (async, active-low), CE_R/CE_F CPU phase enables
//   A, DI, DO, CS_N, RD_N, WRH_N, WRL_N, WAIT_N : CPU bus side
//   MEM_A, MEM_AREA, MEM_DO, MEM_BE, MEM_WE, MEM_REQ, MEM_DI, MEM_ACK : memory
//   ERR : one-CLK pulse when an access times out
module sh_ext_bus_responder
  import sh7034_pkg::*;
#(
  parameter logic [7:0] AREA_EN = 8'h01,
  parameter logic [7:0] AREA16  = 8'h01,
  parameter int         TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic [23:0] A,
  input  logic [15:0] DI,
  output logic [15:0] DO,
  input  logic [7:0]  CS_N,
  input  logic        RD_N,
  input  logic        WRH_N,
  input  logic        WRL_N,
  output logic        WAIT_N,
  output logic [23:0] MEM_A,
  output logic [2:0]  MEM_AREA,
  output logic [15:0] MEM_DO,
  output logic [1:0]  MEM_BE,
  output logic        MEM_WE,
  output logic        MEM_REQ,
  input  logic [15:0] MEM_DI,
  input  logic        MEM_ACK,
  output logic        ERR
);

  localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

  // {hit, index}; scanning downwards lets the lowest enabled area win
  function automatic logic [3:0] pick_area(
    input logic [7:0] cs_n
  );
    logic [3:0] res;
    res = 4'h0;
    for (int i = 7; i >= 0; i--) begin
      if (!cs_n[i] && AREA_EN[i]) begin
        res = {1'b1, 3'(i)};
      end
    end
    return res;
  endfunction

  ExtRespState_t state;
  logic [3:0]    hit;
  logic          sel;
  logic          stb;
  logic          wide;
  logic          is_rd;
  logic          is16;
  logic [7:0]    cnt;
  logic [8:0]    cnt_nx;

  assign hit    = pick_area(CS_N);
  assign sel    = hit[3];
  assign stb    = !RD_N || !WRH_N || !WRL_N;
  assign wide   = AREA16[hit[2:0]];
  assign cnt_nx = {1'b0, cnt} + 9'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      DO       <= EXT_OPEN_BUS;
      WAIT_N   <= 1'b1;
      MEM_REQ  <= 1'b0;
      MEM_WE   <= 1'b0;
      MEM_BE   <= 2'b00;
      MEM_A    <= 24'h0;
      MEM_AREA <= 3'h0;
      MEM_DO   <= 16'h0;
      ERR      <= 1'b0;
      is_rd    <= 1'b0;
      is16     <= 1'b0;
      cnt      <= 8'h0;
    end else begin
      ERR <= 1'b0;
      unique case (state)
        IDLE: begin
          if (CE_F && sel && stb) begin
            MEM_AREA <= hit[2:0];
            is16     <= wide;
            is_rd    <= !RD_N;
            if (wide) begin
              MEM_A  <= {A[23:1], 1'b0};
              MEM_BE <= !RD_N ? 2'b11 : {!WRH_N, !WRL_N};
              MEM_DO <= DI;
            end else begin
              MEM_A  <= A;
              MEM_BE <= 2'b01;
              MEM_DO <= {8'h00, DI[7:0]};
            end
            MEM_WE  <= RD_N;
            MEM_REQ <= 1'b1;
            WAIT_N  <= 1'b0;
            cnt     <= 8'h0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          // strobe release wins over a same-cycle ack
          if (CE_F && !stb) begin
            MEM_REQ <= 1'b0;
            WAIT_N  <= 1'b1;
            state   <= IDLE;
          end else if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
            if (is_rd) begin
              DO <= is16 ? MEM_DI : {8'h00, MEM_DI[7:0]};
            end
            state <= HOLD;
          end else if (CE_R) begin
            if (cnt != 8'hFF) begin
              cnt <= cnt_nx[7:0];
            end
            if (cnt_nx >= TO_LIM) begin
              MEM_REQ <= 1'b0;
              DO      <= EXT_OPEN_BUS;
              ERR     <= 1'b1;
              state   <= HOLD;
            end
          end
        end
        HOLD: begin
          // WAIT_N rises on a CE_F edge so it is stable across CE_R
          if (CE_F) begin
            if (!WAIT_N) begin
              WAIT_N <= 1'b1;
            end else if (!stb) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sh_ext_bus_responder.sv
// Bench for sh_ext_bus_responder: CPU bus driver, memory responder,
// scoreboard queues for memory requests and CPU read data.
module tb_sh_ext_bus_responder;

  localparam logic [7:0] AEN = 8'h0F;
  localparam logic [7:0] A16 = 8'h03;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] ph = 2'd0;
  logic ce_r, ce_f;
  logic [23:0] a_s = 24'h0;
  logic [15:0] di_s = 16'h0;
  logic [15:0] cpu_do;
  logic [7:0] cs_n = 8'hFF;
  logic rd_n = 1'b1, wrh_n = 1'b1, wrl_n = 1'b1;
  logic wait_n;
  logic [23:0] mem_a;
  logic [2:0] mem_area;
  logic [15:0] mem_do;
  logic [1:0] mem_be;
  logic mem_we, mem_req;
  logic [15:0] mem_di = 16'h0;
  logic mem_ack = 1'b0;
  logic err;

  always #5 clk = ~clk;
  always @(posedge clk) ph <= ph + 2'd1;
  assign ce_r = (ph == 2'd0);
  assign ce_f = (ph == 2'd2);

  sh_ext_bus_responder #(
    .AREA_EN(AEN), .AREA16(A16), .TIMEOUT(4)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .CE_F(ce_f),
    .A(a_s), .DI(di_s), .DO(cpu_do), .CS_N(cs_n),
    .RD_N(rd_n), .WRH_N(wrh_n), .WRL_N(wrl_n), .WAIT_N(wait_n),
    .MEM_A(mem_a), .MEM_AREA(mem_area), .MEM_DO(mem_do),
    .MEM_BE(mem_be), .MEM_WE(mem_we), .MEM_REQ(mem_req),
    .MEM_DI(mem_di), .MEM_ACK(mem_ack), .ERR(err)
  );

  typedef struct {
    logic [23:0] a;
    logic [2:0]  area;
    logic [15:0] d;
    logic [1:0]  be;
    logic        we;
  } req_t;

  typedef struct {
    logic        rd;
    logic [15:0] d;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  logic [15:0] rdmem[int];

  int checks = 0;
  int fails = 0;
  int pushes = 0;
  int req_rises = 0;
  int err_cnt = 0;
  int cer_cnt = 0;
  int cer_at_err = -1;
  int ack_dly = -1;
  bit no_ack = 1'b0;
  logic prev_req = 1'b0;
  logic wait_q = 1'b1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rdval(input int area,
                                        input logic [23:0] a);
    int key;
    key = area * 16777216 + int'(a);
    if (rdmem.exists(key)) return rdmem[key];
    return 16'(int'(a) * 37 + area * 101) ^ 16'hC3A5;
  endfunction

  // memory side: checks each request against the scoreboard, then acks
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mem_req) begin
        req_rises++;
        chk("req_expected", 64'(exp_req.size() != 0), 64'd1);
        if (exp_req.size() != 0) begin
          req_t e;
          e = exp_req.pop_front();
          chk("mem_a", 64'(mem_a), 64'(e.a));
          chk("mem_area", 64'(mem_area), 64'(e.area));
          chk("mem_be", 64'(mem_be), 64'(e.be));
          chk("mem_we", 64'(mem_we), 64'(e.we));
          if (e.we) chk("mem_do", 64'(mem_do), 64'(e.d));
        end
        if (!no_ack) begin
          repeat (ack_dly >= 0 ? ack_dly : $urandom_range(0, 3))
            @(negedge clk);
          mem_di = rdval(int'(mem_area), mem_a);
          mem_ack = 1'b1;
          @(negedge clk);
          mem_ack = 1'b0;
          mem_di = 16'($urandom);
        end else begin
          for (int n = 0; n < 200 && mem_req; n++) @(negedge clk);
        end
      end
    end
  end

  // CPU data monitor: read data checked when WAIT_N is released
  always @(negedge clk) begin
    if (rst_n && !wait_q && wait_n) begin
      if (exp_rsp.size() == 0) begin
        chk("rsp_expected", 64'd0, 64'd1);
      end else begin
        rsp_t r;
        r = exp_rsp.pop_front();
        if (r.rd) chk("cpu_do", 64'(cpu_do), 64'(r.d));
      end
    end
    wait_q = wait_n;
    if (mem_req && !prev_req) cer_cnt = 0;
    if (mem_req && ce_r) cer_cnt++;
    prev_req = mem_req;
    if (err) begin
      err_cnt++;
      cer_at_err = cer_cnt;
    end
  end

  task automatic to_cer_edge();
    do @(negedge clk); while (!ce_r);
    @(posedge clk);
    #1;
  endtask

  task automatic to_cef_neg();
    do @(negedge clk); while (!ce_f);
  endtask

  task automatic cpu(input logic [7:0] csn, input logic [23:0] a,
                     input logic rd, input logic [1:0] wr_n,
                     input logic [15:0] di, input bit keep_cs);
    int n;
    to_cer_edge();
    cs_n = csn;
    a_s = a;
    di_s = di;
    rd_n = !rd;
    wrh_n = rd ? 1'b1 : wr_n[1];
    wrl_n = rd ? 1'b1 : wr_n[0];
    to_cef_neg();
    n = 0;
    do begin
      to_cef_neg();
      n++;
    end while (!wait_n && n < 400);
    if (n >= 400) chk("cpu_wait_bound", 64'd0, 64'd1);
    to_cer_edge();
    rd_n = 1'b1;
    wrh_n = 1'b1;
    wrl_n = 1'b1;
    if (!keep_cs) cs_n = 8'hFF;
  endtask

  task automatic access(input int area, input logic [23:0] a,
                        input logic rd, input logic [1:0] wr_n,
                        input logic [15:0] di, input bit keep_cs,
                        input logic [7:0] extra_cs);
    req_t e;
    rsp_t r;
    logic w16;
    logic [15:0] v;
    logic [7:0] csn;
    w16 = A16[area];
    e.area = 3'(area);
    e.we = !rd;
    e.a = w16 ? {a[23:1], 1'b0} : a;
    e.be = !w16 ? 2'b01 : (rd ? 2'b11 : ~wr_n);
    e.d = w16 ? di : {8'h00, di[7:0]};
    exp_req.push_back(e);
    pushes++;
    v = rdval(area, e.a);
    r.rd = rd;
    r.d = no_ack ? 16'hFFFF : (w16 ? v : {8'h00, v[7:0]});
    exp_rsp.push_back(r);
    csn = 8'hFF;
    csn[area] = 1'b0;
    cpu(csn & extra_cs, a, rd, wr_n, di, keep_cs);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_do", 64'(cpu_do), 64'hFFFF);
    chk("rst_wait_n", 64'(wait_n), 64'd1);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_be", 64'(mem_be), 64'd0);
    chk("rst_a", 64'(mem_a), 64'd0);
    chk("rst_area", 64'(mem_area), 64'd0);
    chk("rst_mdo", 64'(mem_do), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;

    rdmem[24'h000102] = 16'hBEEF;
    ack_dly = 3;
    access(0, 24'h000102, 1'b1, 2'b11, 16'h0, 1'b0, 8'hFF);
    ack_dly = -1;
    access(0, 24'h000400, 1'b0, 2'b01, 16'h5A00, 1'b0, 8'hFF);
    access(2, 24'h001000, 1'b0, 2'b10, 16'hC311, 1'b1, 8'hFF);
    access(2, 24'h001001, 1'b0, 2'b10, 16'hC322, 1'b1, 8'hFF);
    access(2, 24'h001002, 1'b0, 2'b10, 16'hC333, 1'b1, 8'hFF);
    access(2, 24'h001003, 1'b0, 2'b10, 16'hC344, 1'b0, 8'hFF);
    access(2, 24'h001003, 1'b1, 2'b11, 16'h0, 1'b0, 8'hFF);
    access(1, 24'h020031, 1'b1, 2'b11, 16'h0, 1'b0, 8'hF7);

    // disabled area: no request, no wait
    to_cer_edge();
    cs_n = 8'hDF;
    rd_n = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_req || !wait_n) n++;
    end
    chk("area5_ignored", 64'(n), 64'd0);
    to_cer_edge();
    rd_n = 1'b1;
    cs_n = 8'hFF;

    // timeout, then a stray ack
    no_ack = 1'b1;
    err_cnt = 0;
    access(0, 24'h000300, 1'b1, 2'b11, 16'h0, 1'b0, 8'hFF);
    chk("err_pulses", 64'(err_cnt), 64'd1);
    chk("err_after_cer", 64'(cer_at_err), 64'd4);
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_wait", 64'(wait_n), 64'd1);
    chk("stray_req", 64'(mem_req), 64'd0);
    chk("stray_do", 64'(cpu_do), 64'hFFFF);
    no_ack = 1'b0;
    access(3, 24'h000777, 1'b1, 2'b11, 16'h0, 1'b0, 8'hFF);

    // reset in the middle of an access
    no_ack = 1'b1;
    begin
      req_t e;
      e.a = 24'h000200;
      e.area = 3'd0;
      e.be = 2'b11;
      e.we = 1'b0;
      e.d = 16'h0;
      exp_req.push_back(e);
      pushes++;
    end
    to_cer_edge();
    cs_n = 8'hFE;
    a_s = 24'h000200;
    rd_n = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_req_seen", 64'(mem_req), 64'd1);
    chk("rst_mid_wait_low", 64'(wait_n), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 64'(mem_req), 64'd0);
    chk("rst_mid_wait", 64'(wait_n), 64'd1);
    chk("rst_mid_do", 64'(cpu_do), 64'hFFFF);
    rd_n = 1'b1;
    cs_n = 8'hFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    no_ack = 1'b0;
    access(0, 24'h000102, 1'b1, 2'b11, 16'h0, 1'b0, 8'hFF);

    for (int i = 0; i < 24; i++) begin
      int ar;
      logic rd;
      logic [1:0] wn;
      ar = $urandom_range(0, 3);
      rd = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: wn = 2'b00;
        1: wn = 2'b01;
        default: wn = 2'b10;
      endcase
      if (!A16[ar]) wn = 2'b10;
      access(ar, 24'($urandom), rd, wn, 16'($urandom), 1'b0, 8'hFF);
    end

    repeat (8) @(negedge clk);
    chk("req_count", 64'(req_rises), 64'(pushes));
    chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
    chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
